// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter using reverse double-dabble.
// Each iteration shifts {bcd_r,bin_r} right by one bit. It then subtracts 3 from
// every BCD digit that reached 8 or more. After BW iterations bin_r holds the
// binary value. Digits above 9 are rejected at once with err=1.
module bcd_to_bin_seq #(
   parameter  int NDIGITS = 4,
   localparam int BW      = $clog2(10**NDIGITS)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [4*NDIGITS-1:0]   bcd_in,
   output logic [BW-1:0]          b,
   output logic                   busy,
   output logic                   done,
   output logic                   err
);

   localparam int DW = 4 * NDIGITS;
   localparam int CW = $clog2(BW + 1);

   typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

   state_t          state, state_n;
   logic [DW-1:0]   bcd_r;
   logic [BW-1:0]   bin_r;
   logic [CW-1:0]   count;

   logic [DW+BW-1:0] shifted;
   logic [DW-1:0]    bcd_nx;
   logic [BW-1:0]    bin_nx;
   logic             accept;
   logic             bad;
   logic             last;

   // True when any packed digit is outside 0..9.
   function automatic logic has_bad_digit(input logic [DW-1:0] d);
      logic r;
      r = 1'b0;
      for (int i = 0; i < NDIGITS; i++) begin
         if (d[4*i +: 4] > 4'd9) r = 1'b1;
      end
      return r;
   endfunction

   // Undo the add-3 step of double-dabble: every digit >= 8 loses 3 (mod 16).
   function automatic logic [DW-1:0] sub3_adjust(input logic [DW-1:0] d);
      logic [DW-1:0] r;
      r = d;
      for (int i = 0; i < NDIGITS; i++) begin
         if (d[4*i +: 4] >= 4'd8) r[4*i +: 4] = d[4*i +: 4] - 4'd3;
      end
      return r;
   endfunction

   // Next-state logic and the combinational part of one conversion iteration.
   always_comb begin
      state_n = state;
      shifted = {bcd_r, bin_r} >> 1;
      bcd_nx  = sub3_adjust(shifted[DW+BW-1:BW]);
      bin_nx  = shifted[BW-1:0];
      accept  = start && (state != CONV);
      bad     = has_bad_digit(bcd_in);
      last    = (count == CW'(BW - 1));
      case (state)
         IDLE, DONE: begin
            if (accept) state_n = bad ? DONE : CONV;
            else        state_n = IDLE;
         end
         CONV: begin
            if (last) state_n = DONE;
         end
         default: state_n = IDLE;
      endcase
   end

   // State register; reset aborts any conversion in progress.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   // Registered outputs, iteration counter and result capture.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         b     <= '0;
         err   <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
         count <= '0;
      end else begin
         busy <= (state_n == CONV);
         done <= (state_n == DONE);
         if (accept && bad) begin
            b   <= '0;
            err <= 1'b1;
         end else if (accept) begin
            count <= '0;
         end else if (state == CONV) begin
            count <= count + CW'(1);
            if (last) begin
               b   <= bin_nx;
               err <= 1'b0;
            end
         end
      end
   end

   // Shift registers holding the digits being consumed and the growing binary value.
   always_ff @(posedge clk) begin
      if (accept) begin
         bcd_r <= bcd_in;
         bin_r <= '0;
      end else if (state == CONV) begin
         bcd_r <= bcd_nx;
         bin_r <= bin_nx;
      end
   end

   // All BCD weight must have migrated into bin_r by the final iteration.
   bcd_drained: assert property (@(posedge clk) disable iff (!rst_n)
      (state == CONV && last) |-> (bcd_nx == '0));

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed bench for bcd_to_bin_seq with a timeline-based reference model.
module tb_bcd_to_bin_seq;

   localparam int NDIGITS = 4;
   localparam int BW      = 14;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 start;
   logic [4*NDIGITS-1:0] bcd_in;
   logic [BW-1:0]        b;
   logic                 busy;
   logic                 done;
   logic                 err;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   bcd_to_bin_seq #(.NDIGITS(NDIGITS)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .bcd_in (bcd_in),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .err    (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %0d (0x%h) expected %0d (0x%h)", name, $time, act, act, exp, exp);
      end
   endtask

   function automatic int bcd_value(input logic [4*NDIGITS-1:0] d);
      int v;
      v = 0;
      for (int i = NDIGITS - 1; i >= 0; i--) v = v * 10 + int'(d[4*i +: 4]);
      return v;
   endfunction

   function automatic bit bcd_bad(input logic [4*NDIGITS-1:0] d);
      bit r;
      r = 1'b0;
      for (int i = 0; i < NDIGITS; i++) if (d[4*i +: 4] > 4'd9) r = 1'b1;
      return r;
   endfunction

   function automatic logic [4*NDIGITS-1:0] to_bcd(input int v);
      logic [4*NDIGITS-1:0] r;
      int t;
      t = v;
      for (int i = 0; i < NDIGITS; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   // Reference model: tracks the edge at which the current request must finish.
   int            edge_n    = 0;
   int            done_edge = -1;
   logic [BW-1:0] p_b       = '0;
   logic          p_err     = 1'b0;
   logic          m_busy    = 1'b0;
   logic          m_done    = 1'b0;
   logic [BW-1:0] m_b       = '0;
   logic          m_err     = 1'b0;

   always @(posedge clk) begin : model
      int            nde;
      logic [BW-1:0] npb;
      logic          npe;
      if (rst_n !== 1'b1) begin
         done_edge <= -1;
         m_busy    <= 1'b0;
         m_done    <= 1'b0;
         m_b       <= '0;
         m_err     <= 1'b0;
      end else begin
         nde = done_edge;
         npb = p_b;
         npe = p_err;
         if (start === 1'b1 && !m_busy) begin
            if (bcd_bad(bcd_in)) begin
               nde = edge_n;
               npb = '0;
               npe = 1'b1;
            end else begin
               nde = edge_n + BW;
               npb = BW'(bcd_value(bcd_in));
               npe = 1'b0;
            end
         end
         done_edge <= nde;
         p_b       <= npb;
         p_err     <= npe;
         m_done    <= (nde == edge_n);
         m_busy    <= (nde > edge_n);
         if (nde == edge_n) begin
            m_b   <= npb;
            m_err <= npe;
         end
      end
      edge_n <= edge_n + 1;
   end

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc_busy", 32'(busy), 32'(m_busy));
         check("cyc_done", 32'(done), 32'(m_done));
         check("cyc_b",    32'(b),    32'(m_b));
         check("cyc_err",  32'(err),  32'(m_err));
      end
   end

   task automatic start_pulse(input logic [4*NDIGITS-1:0] v);
      start  = 1'b1;
      bcd_in = v;
      @(negedge clk);
      start  = 1'b0;
   endtask

   // Returns at the negedge where done is high; lat counts negedges from the start edge.
   task automatic wait_done(output int lat, output int bcnt);
      lat  = 1;
      bcnt = 0;
      while (done !== 1'b1 && lat < 40) begin
         if (busy === 1'b1) bcnt++;
         @(negedge clk);
         lat++;
      end
      check("done_seen", 32'(done), 32'd1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, bcnt;
      logic [4*NDIGITS-1:0] v;
      int pos;

      rst_n  = 1'b0;
      start  = 1'b0;
      bcd_in = '0;
      @(negedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      check("rst_b",    32'(b),    32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err",  32'(err),  32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // zero input: latency and busy length
      start_pulse(16'h0000);
      wait_done(lat, bcnt);
      check("zero_lat",  32'(lat),  32'd15);
      check("zero_busy", 32'(bcnt), 32'd14);
      check("zero_b",    32'(b),    32'd0);
      check("zero_err",  32'(err),  32'd0);
      @(negedge clk);

      // maximum value and a mixed value
      start_pulse(16'h9999);
      wait_done(lat, bcnt);
      check("max_b",   32'(b),   32'h270F);
      check("max_err", 32'(err), 32'd0);
      start_pulse(16'h1049);
      wait_done(lat, bcnt);
      check("b1049", 32'(b), 32'd1049);
      check("b1049_lat", 32'(lat), 32'd15);
      @(negedge clk);

      // invalid tens digit
      start_pulse(16'h12A4);
      wait_done(lat, bcnt);
      check("bad_lat",  32'(lat),  32'd1);
      check("bad_busy", 32'(bcnt), 32'd0);
      check("bad_b",    32'(b),    32'd0);
      check("bad_err",  32'(err),  32'd1);
      @(negedge clk);

      // start during CONV is ignored; start in DONE is accepted
      start_pulse(16'h0123);
      repeat (3) @(negedge clk);
      start_pulse(16'h8000);
      wait_done(lat, bcnt);
      check("ign_b",   32'(b),   32'd123);
      check("ign_err", 32'(err), 32'd0);
      start_pulse(16'h0042);
      wait_done(lat, bcnt);
      check("b2b_lat", 32'(lat), 32'd15);
      check("b2b_b",   32'(b),   32'd42);
      @(negedge clk);

      // reset in the middle of a conversion
      start_pulse(16'h4095);
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("abort_b",    32'(b),    32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_err",  32'(err),  32'd0);
      start_pulse(16'h4095);
      wait_done(lat, bcnt);
      check("after_rst_b", 32'(b), 32'd4095);
      @(negedge clk);

      // strided sweep of valid values, back-to-back
      for (int n = 0; n < 10000; n += 7) begin
         start_pulse(to_bcd(n));
         wait_done(lat, bcnt);
         check("sweep_b",   32'(b),   32'(n));
         check("sweep_err", 32'(err), 32'd0);
      end

      // random invalid-digit patterns
      for (int i = 0; i < 20; i++) begin
         v   = to_bcd(int'($urandom_range(0, 9999)));
         pos = int'($urandom_range(0, NDIGITS - 1));
         v[4*pos +: 4] = 4'($urandom_range(10, 15));
         start_pulse(v);
         wait_done(lat, bcnt);
         check("inv_err", 32'(err), 32'd1);
         check("inv_b",   32'(b),   32'd0);
         check("inv_lat", 32'(lat), 32'd1);
      end

      @(negedge clk);
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
